// File: rtl/cache_main_mem.sv
// Main-memory responder for the data cache: posted one-cycle writes, fixed-latency reads.
// Optional saturating access counters are enabled with CACHE_MEM_PERF_CNT_EN.
module cache_main_mem #(
  parameter int ADDR_WIDTH = 10,
  parameter int RD_LATENCY = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        cache_op,
  input  logic        cache_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] cache_write_data,
  output logic        mem_ready,
  output logic [31:0] mem_data,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] READ_WAIT = 2'd1;
  localparam logic [1:0] READ_DONE = 2'd2;

  localparam int CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  logic [1:0]            state;
  logic [CW-1:0]         lat_cnt;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  wr_accept;
  logic                  rd_accept;
  logic [31:0]           ram [2**ADDR_WIDTH];
  logic                  unused_addr_bits;

  // Handshake: a request (cache_valid) is taken only in IDLE on the sampling edge;
  // writes are posted with no response, reads answer with one mem_ready pulse and
  // cache_valid is ignored until the FSM is back in IDLE.
  assign word_idx         = mem_addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};
  assign wr_accept        = (state == IDLE) && cache_valid && !cache_op;
  assign rd_accept        = (state == IDLE) && cache_valid && cache_op;
  assign state_dbg        = state;

  // Backing RAM is deliberately not reset so contents survive a mid-read reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      ram[word_idx] <= cache_write_data;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      rd_idx    <= '0;
      mem_ready <= 1'b0;
      mem_data  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          mem_ready <= 1'b0;
          if (rd_accept) begin
            rd_idx  <= word_idx;
            lat_cnt <= CW'(RD_LATENCY - 1);
            state   <= READ_WAIT;
          end
        end
        READ_WAIT: begin
          if (lat_cnt == '0) begin
            mem_data  <= ram[rd_idx];
            mem_ready <= 1'b1;
            state     <= READ_DONE;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        READ_DONE: begin
          mem_ready <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          mem_ready <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_MEM_PERF_CNT_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_count <= 16'h0;
      wr_count <= 16'h0;
    end else begin
      if (rd_accept && (rd_count != 16'hFFFF)) begin
        rd_count <= rd_count + 16'd1;
      end
      if (wr_accept && (wr_count != 16'hFFFF)) begin
        wr_count <= wr_count + 16'd1;
      end
    end
  end
`else
  assign rd_count = 16'h0;
  assign wr_count = 16'h0;
`endif

endmodule
